// File: rtl/param_seq_detect.sv
// Runtime-programmable serial bit-pattern detector.
// Sliding history window, overlap select, saturating match counter.
module param_seq_detect #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W = $clog2(MAX_LEN + 1),
   parameter int CNT_W = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1101),
   parameter int DEF_LEN = 4,
   parameter bit DEF_OVERLAP = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             cnt_clr,
   input  logic             in_valid,
   input  logic             data,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             cfg_err
);

   localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);
   localparam logic [LEN_W:0]   ONE  = (LEN_W + 1)'(1);

   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   len;
   logic               overlap;
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;

   logic [MAX_LEN:0]   window;
   logic [MAX_LEN:0]   mask;
   logic [LEN_W-1:0]   fill_inc;
   logic               len_ok;
   logic               fill_ok;
   logic               hit;
   logic               accept;
   logic               do_match;

   // Compare the newest len bits (history plus incoming bit) against the pattern
   always_comb begin
      window   = {hist, data};
      mask     = '0;
      for (int i = 0; i <= MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
      len_ok   = (cfg_len != '0) && (cfg_len <= FULL);
      fill_ok  = ({1'b0, fill} + ONE) >= {1'b0, len};
      hit      = ((window ^ {1'b0, pattern}) & mask) == '0;
      accept   = in_valid & ~cfg_we;
      do_match = accept & fill_ok & hit;
      fill_inc = (fill == FULL) ? fill : fill + LEN_W'(1);
   end

   // Configuration, history, pulses and counter share one register process
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pattern     <= DEF_PATTERN;
         len         <= LEN_W'(DEF_LEN);
         overlap     <= DEF_OVERLAP;
         hist        <= '0;
         fill        <= '0;
         match       <= 1'b0;
         cfg_err     <= 1'b0;
         match_count <= '0;
      end else begin
         match   <= 1'b0;
         cfg_err <= 1'b0;
         if (cfg_we) begin
            if (len_ok) begin
               pattern <= cfg_pattern;
               len     <= cfg_len;
               overlap <= cfg_overlap;
               hist    <= '0;
               fill    <= '0;
            end else begin
               cfg_err <= 1'b1;
            end
         end else if (in_valid) begin
            hist  <= {hist[MAX_LEN-2:0], data};
            match <= do_match;
            if (do_match && !overlap) begin
               fill <= '0;
            end else begin
               fill <= fill_inc;
            end
         end
         if (cnt_clr) begin
            match_count <= '0;
         end else if (do_match && !(&match_count)) begin
            match_count <= match_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_param_seq_detect.sv
// Directed bench for param_seq_detect with a scoreboard queue.
// Two instances share stimulus: 8-bit and 2-bit match counters.
module tb_param_seq_detect;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       cnt_clr;
   logic       in_valid;
   logic       data;

   logic       m8, e8, m2, e2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_pat;
   int         m_len;
   bit         m_ov;
   bit         hq[$];
   int         c8, c2;
   logic [1:0] sb[$];

   always #5 clk = ~clk;

   param_seq_detect #(.CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .in_valid(in_valid), .data(data),
      .match(m8), .match_count(cnt8), .cfg_err(e8)
   );

   param_seq_detect #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .in_valid(in_valid), .data(data),
      .match(m2), .match_count(cnt2), .cfg_err(e2)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pat = 8'h0D;
      m_len = 4;
      m_ov  = 1'b1;
      hq.delete();
      c8 = 0;
      c2 = 0;
   endtask

   task automatic cyc(input bit v, input bit d, input bit we,
                      input bit clr, input logic [7:0] pat,
                      input logic [3:0] ln, input bit ov);
      bit em, ee, ok;
      logic [1:0] e;
      in_valid    = v;
      data        = d;
      cfg_we      = we;
      cnt_clr     = clr;
      cfg_pattern = pat;
      cfg_len     = ln;
      cfg_overlap = ov;
      em = 1'b0;
      ee = 1'b0;
      if (we) begin
         if (ln >= 1 && ln <= 8) begin
            m_pat = pat;
            m_len = int'(ln);
            m_ov  = ov;
            hq.delete();
         end else begin
            ee = 1'b1;
         end
      end else if (v) begin
         hq.push_back(d);
         if (hq.size() > 8) void'(hq.pop_front());
         if (hq.size() >= m_len) begin
            ok = 1'b1;
            for (int i = 0; i < m_len; i++) begin
               if (hq[hq.size() - 1 - i] != m_pat[i]) ok = 1'b0;
            end
            em = ok;
            if (em && !m_ov) hq.delete();
         end
      end
      if (clr) begin
         c8 = 0;
         c2 = 0;
      end else if (em) begin
         c8 = (c8 == 255) ? 255 : c8 + 1;
         c2 = (c2 == 3) ? 3 : c2 + 1;
      end
      sb.push_back({em, ee});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("match", 32'(m8), 32'(e[1]));
      check("match_w2", 32'(m2), 32'(e[1]));
      check("cfg_err", 32'(e8), 32'(e[0]));
      check("count8", 32'(cnt8), 32'(c8));
      check("count2", 32'(cnt2), 32'(c2));
   endtask

   task automatic b(input bit d);
      cyc(1'b1, d, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
   endtask

   task automatic idle(input bit d);
      cyc(1'b0, d, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
   endtask

   task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                      input bit o);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, p, l, o);
   endtask

   task automatic rst_now();
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_match", 32'(m8), 32'd0);
      check("rst_count8", 32'(cnt8), 32'd0);
      check("rst_count2", 32'(cnt2), 32'd0);
      check("rst_err", 32'(e8), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset       = 1'b0;
      cfg_we      = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      cnt_clr     = 1'b0;
      in_valid    = 1'b0;
      data        = 1'b0;
      model_reset();
      #1;
      check("init_match", 32'(m8), 32'd0);
      check("init_count", 32'(cnt8), 32'd0);
      check("init_err", 32'(e8), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // defaults: 1101 overlapping
      b(1); b(1); b(0); b(1); b(1); b(0); b(1);
      check("dflt_total", 32'(cnt8), 32'd2);

      // non-overlapping
      cfg(8'h0D, 4'd4, 1'b0);
      b(1); b(1); b(0); b(1); b(1); b(0); b(1);
      check("novl_total", 32'(cnt8), 32'd3);

      // gapped stream, data toggling high while idle
      cfg(8'h0D, 4'd4, 1'b0);
      b(1); idle(1); idle(1);
      b(1); idle(1); idle(1);
      b(0); idle(1); idle(1);
      b(1); idle(1); idle(1);
      check("gap_total", 32'(cnt8), 32'd4);

      // length 1 and counter saturation
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
      cfg(8'h01, 4'd1, 1'b1);
      b(1); b(0); b(1); b(1);
      check("len1_total", 32'(cnt8), 32'd3);
      b(1); b(1);
      check("sat_c8", 32'(cnt8), 32'd5);
      check("sat_c2", 32'(cnt2), 32'd3);

      // clear coincident with a match
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
      check("clr_win", 32'(cnt8), 32'd0);

      // full-length pattern
      cfg(8'hAA, 4'd8, 1'b1);
      b(1); b(0); b(1); b(0); b(1);
      b(0); b(1); b(0); b(1); b(0);
      check("len8_total", 32'(cnt8), 32'd2);

      // illegal lengths with concurrent data
      cfg(8'h0D, 4'd4, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 4'd0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 4'd9, 1'b0);
      b(1); b(1); b(0); b(1);
      check("post_err_total", 32'(cnt8), 32'd3);

      // reset while match pulse is high
      rst_now();

      // reset mid-pattern
      b(1); b(1); b(0);
      rst_now();
      b(1);
      check("post_rst_total", 32'(cnt8), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_seq_detect.md
Name: param_seq_detect

Overview:
Runtime-programmable serial bit-pattern detector, the parametrised successor to the fixed 1101 detector. It takes a qualified serial bit stream and compares a sliding history window against a pattern of 1..MAX_LEN bits. It flags each match with a registered one-cycle pulse and keeps a saturating match count. Overlapping or non-overlapping detection is selected at configuration time; it sits on any serial input path needing framing/sync-word detection.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of length fields (derived, not overridden)
CNT_W, 8, match counter width
DEF_PATTERN, 8'b0000_1101, pattern loaded at reset (low DEF_LEN bits used)
DEF_LEN, 4, pattern length loaded at reset
DEF_OVERLAP, 1, overlap mode loaded at reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  configuration write strobe
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] = first bit received, bit [0] = last bit received
cfg_len  in  LEN_W  pattern length, legal range 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches, 0 = history restarts after a match
cnt_clr  in  1  synchronous clear of match_count
in_valid  in  1  data qualifier
data  in  1  serial input bit
match  out  1  registered match pulse
match_count  out  CNT_W  saturating number of matches
cfg_err  out  1  registered pulse, illegal cfg_len rejected

Behaviour:
- Reset (reset=0, async): match=0, match_count=0, cfg_err=0, history=0, fill=0; pattern/len/overlap = DEF_PATTERN/DEF_LEN/DEF_OVERLAP. Outputs take these values immediately, without waiting for a clock edge.
- State: hist[MAX_LEN-1:0] shift register; fill counter 0..MAX_LEN (saturating) counts accepted bits since the last restart.
- Bit accept: at the edge where in_valid=1 and cfg_we=0:
  - hist <= {hist[MAX_LEN-2:0], data}
  - fill <= min(fill+1, MAX_LEN)
- Match condition, evaluated on the same edge:
  - in_valid=1, cfg_we=0, fill+1 >= len, and
  - ({hist,data} low len bits) == (pattern low len bits)
- Latency: match=1 in the cycle after the edge that samples the final pattern bit, and for exactly one cycle. match=0 on any edge without a match, including in_valid=0 edges.
- Overlap mode 1: fill keeps counting, so a match suffix can start the next match.
- Overlap mode 0: on a match, fill <= 0. The next match needs len fresh accepted bits.
- Configuration: cfg_we=1 with 1 <= cfg_len <= MAX_LEN:
  - latch pattern, len and overlap; hist <= 0, fill <= 0, match <= 0
  - a concurrent data bit is discarded
  - match_count is unaffected
- Illegal cfg_len (0 or > MAX_LEN):
  - configuration, hist and fill are unchanged; cfg_err=1 for one cycle
  - a concurrent in_valid bit is still discarded
- Counter:
  - increments on each edge that sets match=1; saturates at 2^CNT_W-1 (no wrap)
  - cnt_clr=1 forces 0 and wins over a simultaneous increment
- Pattern bits above len are ignored.
- in_valid=0: history, fill and count hold.
- Reset asserted mid-pattern: partial history is lost and configuration reverts to defaults.
- Single always_ff for state/outputs with async reset; no latches (every combinational path fully assigned).

Test Plan:
- Defaults (1101, overlap=1): after reset, stream 1,1,0,1,1,0,1 with in_valid=1 each cycle -> match pulses in the cycles after bits 4 and 7; match_count=2.
- Non-overlap: cfg_we with pattern 1101, len 4, overlap 0; same 7-bit stream -> match only after bit 4; match_count=1.
- Gapped input: 1101 stream with 2 idle in_valid=0 cycles between bits -> one match pulse, one cycle wide, after the 4th valid bit; an idle 1 on data during gaps is ignored.
- Length extremes:
  - len=1, pattern 1; stream 1,0,1,1 -> 3 pulses
  - MAX_LEN=8, pattern 10101010, overlap=1; stream 1010101010 -> matches after bits 8 and 10
- Illegal config: cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses each time; pattern 1101 still detected afterwards.
- Counter/reset:
  - CNT_W=2, 5 matches -> match_count holds 3
  - cnt_clr coincident with a match -> 0
  - reset driven low mid-pattern (after bits 1,1,0) -> match and match_count go 0 immediately; following "1" gives no match
